param_bitcounter: RTL and testbench
===================================

# param_bitcounter

Parametrised successor to the lab 4 bit counter. On a start request it loads an operand of configurable width and counts either its one bits or its zero bits, consuming `STEP` bits per clock with early termination once no set bits remain. It sits behind the synchronised `start` from the board top level and drives a result/done pair to the HEX/LEDR display logic.

## Interface
- `WIDTH`, default 8: operand width in bits; legal range is 1 or more.
- `STEP`, default 1: bits consumed per COUNT cycle; legal range is 1 to `WIDTH`.
- `RW`, default `$clog2(WIDTH+1)`: result width (derived; do not override).
- `clock`, in, 1: the single clock; all state changes on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: level request, already synchronised upstream.
- `mode`, in, 1: 0 counts ones, 1 counts zeros.
- `input_a`, in, `WIDTH`: operand.
- `result`, out, `RW`: bit count.
- `done`, out, 1: result valid.
- `busy`, out, 1: high in the COUNT state.

## Operation
- States:
  - **S_IDLE**, the reset state.
  - **S_COUNT**.
  - **S_DONE**.
- **S_IDLE:**
  - If `start`=1 at the edge:
    - load the shift register with `input_a` if `mode`=0, or with `~input_a` if `mode`=1;
    - clear `result` to 0;
    - go to S_COUNT.
  - Otherwise hold; `result` keeps its last value.
- **S_COUNT:**
  - If the shift register is 0: go to S_DONE, with no add.
  - Otherwise:
    - add the popcount of `shreg[STEP-1:0]` to `result`;
    - shift `shreg` right by `STEP` with zero fill;
    - stay in S_COUNT.
- **S_DONE:**
  - Hold `result`.
  - If `start`=1: stay.
  - If `start`=0: go to S_IDLE.
  - A new count requires `start` to be released and reasserted.
- Outputs:
  - `done`=1 only in S_DONE (Moore).
  - `busy`=1 only in S_COUNT.
- Arithmetic:
  - The chunk popcount is `$clog2(STEP+1)` bits, zero-extended to `RW`.
  - `result` can never exceed `WIDTH`, so there is no overflow handling.
- Sampling: `input_a` and `mode` are sampled only on the load edge. Changes during S_COUNT or S_DONE are ignored.
- Reset:
  - Reset forces S_IDLE, `result`=0, `done`=0, `busy`=0 and `shreg`=0.
  - Reset takes priority over `start` in every state.
  - Reset mid-count abandons the operation; no partial result is retained.

## Timing
- Let edge k be the edge at which S_IDLE samples `start`=1.
- Let p be 1 plus the index of the highest set bit of the loaded operand, or p=0 if the operand is zero.
- The state is S_COUNT after edge k, and `busy` rises then.
- `done` rises after edge k+1+ceil(p/`STEP`), and `busy` falls on the same edge.
- `result` is final no later than the same edge on which `done` rises.
- Best case is 2 cycles (operand 0). Worst case is 1+ceil(`WIDTH`/`STEP`)+1 cycles.
- `done` falls on the first edge at which `start`=0 is sampled in S_DONE.
- `start` deasserted during S_COUNT does not abort the count. The FSM still reaches S_DONE and leaves it on the next edge if `start` is still 0; `done` is then high for exactly 1 cycle.

## Structure
- Package `bitcount_pkg` holds:
  - `typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} bc_state_t`;
  - the constants `MODE_ONES`=0 and `MODE_ZEROS`=1.
- One combinational sub-module, `chunk_popcount #(STEP)`: `STEP`-bit input, `$clog2(STEP+1)`-bit count.
- The top level holds the state register, shift register, accumulator and next-state logic, with separate `always_ff` and `always_comb` blocks.

## Test plan
- **Ones, full operand:** `WIDTH`=8, `STEP`=1, `mode`=0, `input_a`=8'hFF, `start` held → `result`=8, `done` after edge k+9, `busy` high for 9 cycles.
- **Zero operand:** `WIDTH`=8, `STEP`=1, `input_a`=8'h00 → `result`=0, `done` after edge k+1.
  - Then `mode`=1 with `input_a`=8'hF0 → `result`=4, `done` after edge k+5.
- **Multi-bit step:** `WIDTH`=8, `STEP`=4, `input_a`=8'h81 → `result`=2, `done` after edge k+3.
  - Also `WIDTH`=16, `STEP`=3, `input_a`=16'hFFFF → `result`=16, `done` after edge k+7.
- **Handshake:**
  - Hold `start` 5 cycles in S_DONE → `done` stays 1 and `result` is stable.
  - Drop `start` → `done`=0 next edge and the state is S_IDLE.
  - Reassert with 8'h03 → `result`=2.
  - Change `input_a` mid-count → no effect on `result`.
- **Reset mid-operation:** assert `reset` at edge k+3 during an 8'hFF count → `result`=0, `done`=0, `busy`=0 after that edge.
  - Then release `reset` with `start` still high → a fresh count from S_IDLE gives `result`=8.
- **Early release:** deassert `start` at edge k+2 of an 8'hFF count → `done` high for exactly 1 cycle after edge k+9, then the state is S_IDLE.

Source files
------------

// File: rtl/bitcount_pkg.sv
// Shared types and constants for the parametrised bit counter.
package bitcount_pkg;

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} bc_state_t;

  localparam logic MODE_ONES  = 1'b0;
  localparam logic MODE_ZEROS = 1'b1;

endpackage

// File: rtl/chunk_popcount.sv
// Combinational population count of one STEP-bit chunk of the shift register.
module chunk_popcount #(
  parameter int STEP = 1,
  parameter int CW   = $clog2(STEP + 1)
) (
  input  logic [STEP-1:0] i_bits,
  output logic [CW-1:0]   o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < STEP; i++) begin
      o_count = o_count + CW'(i_bits[i]);
    end
  end

endmodule

// File: rtl/param_bitcounter.sv
// Counts ones (or zeros) of a WIDTH-bit operand, STEP bits per clock, stopping as
// soon as no set bits remain. Handshake: start is a level request; done (Moore,
// S_DONE only) holds the result until start is released; busy marks S_COUNT.
module param_bitcounter
  import bitcount_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int RW    = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] input_a,
  output logic [RW-1:0]    result,
  output logic             done,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(STEP + 1);

  bc_state_t        r_state;
  bc_state_t        w_state_next;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_next;
  logic [RW-1:0]    r_result;
  logic [RW-1:0]    w_result_next;
  logic [CW-1:0]    w_chunk_cnt;

  chunk_popcount #(.STEP(STEP)) u_chunk (
    .i_bits  (r_shreg[STEP-1:0]),
    .o_count (w_chunk_cnt)
  );

  // Zero counting is ones counting of the inverted operand, so only the load differs.
  always_comb begin
    w_state_next  = r_state;
    w_shreg_next  = r_shreg;
    w_result_next = r_result;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_shreg_next  = (mode == MODE_ZEROS) ? ~input_a : input_a;
          w_result_next = '0;
          w_state_next  = S_COUNT;
        end
      end
      S_COUNT: begin
        if (r_shreg == '0) begin
          w_state_next = S_DONE;
        end else begin
          w_result_next = r_result + RW'(w_chunk_cnt);
          w_shreg_next  = r_shreg >> STEP;
        end
      end
      S_DONE: begin
        if (!start) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_shreg  <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_next;
      r_shreg  <= w_shreg_next;
      r_result <= w_result_next;
    end
  end

  assign result    = r_result;
  assign done      = (r_state == S_DONE);
  assign busy      = (r_state == S_COUNT);
  assign state_dbg = r_state;

endmodule

// File: tb/tb_param_bitcounter.sv
// Bench for param_bitcounter: three configurations share stimulus and are checked
// every cycle against a cycle-count/popcount model, plus literal expectations.
module tb_param_bitcounter;
  import bitcount_pkg::*;

  localparam int NDUT = 3;
  localparam int WS [NDUT] = '{8, 8, 16};
  localparam int SS [NDUT] = '{1, 4, 3};

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic [15:0] a;

  logic [2:0]  done_w;
  logic [2:0]  busy_w;
  logic [3:0]  res0;
  logic [3:0]  res1;
  logic [4:0]  res2;
  logic [1:0]  st0;
  logic [1:0]  st1;
  logic [1:0]  st2;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  param_bitcounter #(.WIDTH(8), .STEP(1)) u_dut0 (
    .clock(clk), .reset(rst), .start(start), .mode(mode), .input_a(a[7:0]),
    .result(res0), .done(done_w[0]), .busy(busy_w[0]), .state_dbg(st0)
  );
  param_bitcounter #(.WIDTH(8), .STEP(4)) u_dut1 (
    .clock(clk), .reset(rst), .start(start), .mode(mode), .input_a(a[7:0]),
    .result(res1), .done(done_w[1]), .busy(busy_w[1]), .state_dbg(st1)
  );
  param_bitcounter #(.WIDTH(16), .STEP(3)) u_dut2 (
    .clock(clk), .reset(rst), .start(start), .mode(mode), .input_a(a),
    .result(res2), .done(done_w[2]), .busy(busy_w[2]), .state_dbg(st2)
  );

  function automatic int get_res(input int i);
    case (i)
      0:       return int'(res0);
      1:       return int'(res1);
      default: return int'(res2);
    endcase
  endfunction

  function automatic int get_st(input int i);
    case (i)
      0:       return int'(st0);
      1:       return int'(st1);
      default: return int'(st2);
    endcase
  endfunction

  task automatic chk(input string name, input int i, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s dut%0d got=%0d want=%0d at %0t", name, i, got, want, $time);
    end
  endtask

  // Model: phase 0 idle, 1 counting, 2 done. Counting lasts ceil(p/STEP)+1 cycles
  // and the answer is just the popcount of the (possibly inverted) operand.
  int m_ph    [NDUT] = '{0, 0, 0};
  int m_cnt   [NDUT] = '{0, 0, 0};
  int m_res   [NDUT] = '{0, 0, 0};
  bit m_valid [NDUT] = '{1'b1, 1'b1, 1'b1};

  function automatic int popc(input logic [31:0] v);
    int n = 0;
    for (int b = 0; b < 32; b++) n += int'(v[b]);
    return n;
  endfunction

  function automatic int hibit_plus1(input logic [31:0] v);
    int p = 0;
    for (int b = 0; b < 32; b++) if (v[b]) p = b + 1;
    return p;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      logic [31:0] op;
      logic [31:0] mask;
      if (rst) begin
        m_ph[i] = 0; m_cnt[i] = 0; m_res[i] = 0; m_valid[i] = 1'b1;
      end else begin
        case (m_ph[i])
          0: if (start) begin
            mask = (32'h1 << WS[i]) - 32'h1;
            op   = (mode ? ~{16'h0, a} : {16'h0, a}) & mask;
            m_res[i]   = popc(op);
            m_cnt[i]   = (hibit_plus1(op) + SS[i] - 1) / SS[i];
            m_ph[i]    = 1;
            m_valid[i] = 1'b0;
          end
          1: if (m_cnt[i] == 0) begin
            m_ph[i] = 2; m_valid[i] = 1'b1;
          end else begin
            m_cnt[i]--;
          end
          default: if (!start) m_ph[i] = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NDUT; i++) begin
        int want_st;
        want_st = (m_ph[i] == 0) ? int'(S_IDLE) : (m_ph[i] == 1) ? int'(S_COUNT) : int'(S_DONE);
        chk("model_busy", i, int'(busy_w[i]), int'(m_ph[i] == 1));
        chk("model_done", i, int'(done_w[i]), int'(m_ph[i] == 2));
        chk("model_state", i, get_st(i), want_st);
        if (m_valid[i]) chk("model_result", i, get_res(i), m_res[i]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Raise start, time done on DUT idx from the load edge, optionally changing the
  // operand or dropping start after a given number of post-load edges.
  task automatic run_op(input int idx, input logic [15:0] opnd, input logic md,
                        input int want_res, input int want_lat,
                        input int mid_at, input logic [15:0] mid_a, input int rel_at);
    int lat = 0;
    int busy_n;
    bit got = 1'b0;
    a = opnd; mode = md; start = 1'b1;
    step();
    busy_n = int'(busy_w[idx]);
    while (lat < 60 && !got) begin
      if (lat == mid_at) a = mid_a;
      if (lat == rel_at) start = 1'b0;
      step();
      lat++;
      if (done_w[idx]) got = 1'b1;
      else if (busy_w[idx]) busy_n++;
    end
    chk("latency", idx, lat, want_lat);
    chk("busy_cycles", idx, busy_n, want_lat);
    chk("result_lit", idx, get_res(idx), want_res);
  endtask

  task automatic release_all();
    int n = 0;
    start = 1'b0;
    step();
    while (n < 40 && (done_w != 3'b000 || busy_w != 3'b000)) begin
      step();
      n++;
    end
    chk("idle_wait", 0, int'(done_w == 3'b000 && busy_w == 3'b000), 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0;
    repeat (2) step();
    chk_en = 1'b1;
    chk("reset_result", 0, get_res(0), 0);
    chk("reset_done", 0, int'(done_w), 0);
    chk("reset_busy", 0, int'(busy_w), 0);
    rst = 1'b0;
    step();

    run_op(0, 16'h00FF, MODE_ONES, 8, 9, -1, 16'h0, -1);
    release_all();
    run_op(0, 16'h0000, MODE_ONES, 0, 1, -1, 16'h0, -1);
    release_all();
    run_op(0, 16'h00F0, MODE_ZEROS, 4, 5, -1, 16'h0, -1);
    release_all();
    run_op(1, 16'h0081, MODE_ONES, 2, 3, -1, 16'h0, -1);
    release_all();
    run_op(2, 16'hFFFF, MODE_ONES, 16, 7, -1, 16'h0, -1);
    release_all();

    // Handshake: hold in done, drop start, then check a mid-count operand change.
    run_op(0, 16'h0003, MODE_ONES, 2, 3, -1, 16'h0, -1);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("hold_done", 0, int'(done_w[0]), 1);
      chk("hold_result", 0, get_res(0), 2);
    end
    start = 1'b0;
    step();
    chk("drop_done", 0, int'(done_w[0]), 0);
    chk("drop_state", 0, get_st(0), int'(S_IDLE));
    release_all();
    run_op(0, 16'h00FF, MODE_ONES, 8, 9, 2, 16'h0000, -1);
    release_all();

    // Reset at edge k+3 of an 8'hFF count, then restart with start still high.
    a = 16'h00FF; mode = MODE_ONES; start = 1'b1;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    chk("rst_mid_result", 0, get_res(0), 0);
    chk("rst_mid_done", 0, int'(done_w[0]), 0);
    chk("rst_mid_busy", 0, int'(busy_w[0]), 0);
    rst = 1'b0;
    run_op(0, 16'h00FF, MODE_ONES, 8, 9, -1, 16'h0, -1);
    release_all();

    // Early release: start sampled low at edge k+2.
    run_op(0, 16'h00FF, MODE_ONES, 8, 9, -1, 16'h0, 1);
    step();
    chk("early_done_fall", 0, int'(done_w[0]), 0);
    chk("early_state", 0, get_st(0), int'(S_IDLE));
    chk("early_result_hold", 0, get_res(0), 8);
    release_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
